// File: rtl/xy2_pkg.sv
// Shared XY2-100 constants, FSM state type and frame/parity helpers.
package xy2_pkg;

  localparam int unsigned XY2_FRAME_BITS = 20;
  localparam int unsigned XY2_DATA_W     = 16;
  // Control bits in wire order, left to right: bit 0, bit 1, bit 2.
  localparam logic [2:0]  XY2_CTRL       = 3'b001;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } xy2_state_e;

  // Parity bit that makes the whole frame even; the control bits contribute a single '1'.
  function automatic logic xy2_parity(input logic [XY2_DATA_W-1:0] data);
    return ~(^data);
  endfunction

  // Frame in transmission order: index 0 is the first bit on the wire.
  function automatic logic [XY2_FRAME_BITS-1:0] xy2_build_frame(
    input logic [XY2_DATA_W-1:0] data
  );
    logic [XY2_FRAME_BITS-1:0] frame;
    frame[0] = XY2_CTRL[2];
    frame[1] = XY2_CTRL[1];
    frame[2] = XY2_CTRL[0];
    for (int k = 0; k < int'(XY2_DATA_W); k++) begin
      frame[3+k] = data[XY2_DATA_W-1-k];
    end
    frame[XY2_FRAME_BITS-1] = xy2_parity(data);
    return frame;
  endfunction

endpackage

// File: rtl/xy2_frame_ser.sv
// One XY2-100 channel: builds the 20-bit frame on load and shifts it out LSB (bit 0) first.
module xy2_frame_ser
  import xy2_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  load_i,
  input  logic                  shift_i,
  input  logic                  clear_i,
  input  logic [XY2_DATA_W-1:0] data_i,
  output logic                  ser_o
);

  logic [XY2_FRAME_BITS-1:0] sr_d, sr_q;

  always_comb begin
    sr_d = sr_q;
    if (clear_i) begin
      sr_d = '0;
    end else if (load_i) begin
      sr_d = xy2_build_frame(data_i);
    end else if (shift_i) begin
      sr_d = {1'b0, sr_q[XY2_FRAME_BITS-1:1]};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_o = sr_q[0];

endmodule

// File: rtl/xy2_100_tx.sv
// XY2-100 transmitter: continuous 20-bit X/Y frames with a single-entry holding register.
// Define XY2_STATUS_RX_EN to enable capture of the receiver's status line.
module xy2_100_tx
  import xy2_pkg::*;
#(
  parameter int unsigned CLK_DIV = 10,
  parameter int unsigned DATA_W  = XY2_DATA_W
) (
  input  logic              clk_ref,
  input  logic              sys_rstn,
  input  logic              enable,
  input  logic [DATA_W-1:0] x_data,
  input  logic [DATA_W-1:0] y_data,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              frame_start,
  output logic              xy_clk,
  output logic              xy_sync,
  output logic              xy_x,
  output logic              xy_y,
  input  logic              xy_status,
  output logic [DATA_W-1:0] status_word,
  output logic              status_valid,
  output logic              status_perr
);

  localparam int unsigned PhW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned BitW = $clog2(XY2_FRAME_BITS);

  localparam logic [PhW-1:0]  PhLast  = PhW'(CLK_DIV - 1);
  localparam logic [PhW-1:0]  PhHalf  = PhW'(CLK_DIV / 2);
  localparam logic [BitW-1:0] BitLast = BitW'(XY2_FRAME_BITS - 1);

  xy2_state_e state_d, state_q;
  logic [PhW-1:0]    phase_d, phase_q;
  logic [BitW-1:0]   bit_d, bit_q;
  logic [DATA_W-1:0] hold_x_d, hold_x_q, hold_y_d, hold_y_q;
  logic [DATA_W-1:0] last_x_d, last_x_q, last_y_d, last_y_q;
  logic              full_d, full_q;
  logic              frame_start_d, frame_start_q;
  logic              xy_clk_d, xy_clk_q, xy_sync_d, xy_sync_q;

  logic              bit_end, frame_end, start, stop, shift, accept;
  logic [DATA_W-1:0] load_x, load_y;

  always_comb begin
    bit_end   = (state_q == StSend) && (phase_q == PhLast);
    frame_end = bit_end && (bit_q == BitLast);
    start     = enable && ((state_q == StIdle) || frame_end);
    stop      = frame_end && !enable;
    shift     = bit_end && !frame_end;
    accept    = data_valid && !full_q;
    // An empty holding register means the last words are sent again.
    load_x    = full_q ? hold_x_q : last_x_q;
    load_y    = full_q ? hold_y_q : last_y_q;

    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    if (start) begin
      state_d = StSend;
      phase_d = '0;
      bit_d   = '0;
    end else if (stop) begin
      state_d = StIdle;
      phase_d = '0;
      bit_d   = '0;
    end else if (state_q == StSend) begin
      if (bit_end) begin
        phase_d = '0;
        bit_d   = bit_q + BitW'(1);
      end else begin
        phase_d = phase_q + PhW'(1);
      end
    end

    hold_x_d = hold_x_q;
    hold_y_d = hold_y_q;
    last_x_d = last_x_q;
    last_y_d = last_y_q;
    full_d   = full_q;
    if (start) begin
      last_x_d = load_x;
      last_y_d = load_y;
      full_d   = 1'b0;
    end
    // A pair accepted on a load cycle lands in holding; the load already used the old content.
    if (accept) begin
      hold_x_d = x_data;
      hold_y_d = y_data;
      full_d   = 1'b1;
    end

    frame_start_d = start;
    xy_clk_d      = (state_d == StSend) && (phase_d < PhHalf);
    xy_sync_d     = (state_d == StSend) && (bit_d != BitLast);
  end

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_q       <= StIdle;
      phase_q       <= '0;
      bit_q         <= '0;
      hold_x_q      <= '0;
      hold_y_q      <= '0;
      last_x_q      <= '0;
      last_y_q      <= '0;
      full_q        <= 1'b0;
      frame_start_q <= 1'b0;
      xy_clk_q      <= 1'b0;
      xy_sync_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      bit_q         <= bit_d;
      hold_x_q      <= hold_x_d;
      hold_y_q      <= hold_y_d;
      last_x_q      <= last_x_d;
      last_y_q      <= last_y_d;
      full_q        <= full_d;
      frame_start_q <= frame_start_d;
      xy_clk_q      <= xy_clk_d;
      xy_sync_q     <= xy_sync_d;
    end
  end

  xy2_frame_ser u_ser_x (
    .clk_i   (clk_ref),
    .rst_ni  (sys_rstn),
    .load_i  (start),
    .shift_i (shift),
    .clear_i (stop),
    .data_i  (load_x),
    .ser_o   (xy_x)
  );

  xy2_frame_ser u_ser_y (
    .clk_i   (clk_ref),
    .rst_ni  (sys_rstn),
    .load_i  (start),
    .shift_i (shift),
    .clear_i (stop),
    .data_i  (load_y),
    .ser_o   (xy_y)
  );

  assign data_ready  = !full_q;
  assign frame_start = frame_start_q;
  assign xy_clk      = xy_clk_q;
  assign xy_sync     = xy_sync_q;

`ifdef XY2_STATUS_RX_EN
  logic [XY2_FRAME_BITS-1:0] st_sr_d, st_sr_q;
  logic [DATA_W-1:0]         st_word_d, st_word_q;
  logic                      st_valid_d, st_valid_q, st_perr_d, st_perr_q;

  always_comb begin
    st_sr_d    = st_sr_q;
    st_word_d  = st_word_q;
    st_perr_d  = st_perr_q;
    st_valid_d = 1'b0;
    // Sample on the xy_clk falling edge; after 20 samples bit 0 sits at index 0.
    if ((state_q == StSend) && (phase_q == PhHalf)) begin
      st_sr_d = {xy_status, st_sr_q[XY2_FRAME_BITS-1:1]};
    end
    if (frame_end) begin
      for (int k = 0; k < int'(DATA_W); k++) begin
        st_word_d[DATA_W-1-k] = st_sr_q[3+k];
      end
      st_valid_d = 1'b1;
      st_perr_d  = (^st_sr_q) | ({st_sr_q[0], st_sr_q[1], st_sr_q[2]} != XY2_CTRL);
    end
  end

  always_ff @(posedge clk_ref or negedge sys_rstn) begin
    if (!sys_rstn) begin
      st_sr_q    <= '0;
      st_word_q  <= '0;
      st_valid_q <= 1'b0;
      st_perr_q  <= 1'b0;
    end else begin
      st_sr_q    <= st_sr_d;
      st_word_q  <= st_word_d;
      st_valid_q <= st_valid_d;
      st_perr_q  <= st_perr_d;
    end
  end

  assign status_word  = st_word_q;
  assign status_valid = st_valid_q;
  assign status_perr  = st_perr_q;
`else
  logic unused_status;
  assign unused_status = xy_status;
  assign status_word   = '0;
  assign status_valid  = 1'b0;
  assign status_perr   = 1'b0;
`endif

endmodule
